syndrome_acc: RTL and testbench

Multi-channel sparse-circulant syndrome accumulator for the KEM datapath. Computes s = s_seed ⊕ Σ_ch (e_ch · h_ch) mod (x^R − 1) over GF(2), where each h_ch is a sparse circulant given as W bit positions. It replaces the fixed two-multiplier syndrome unit with a single time-shared rotate-and-XOR engine, and adds:
- a configurable channel count,
- an optional seed input,
- out-of-range position detection,
- a registered Hamming weight of the result for the decoder threshold logic.

---
 rtl/syndrome_acc.sv | 175 +++++++++++++++++
 tb/tb_syndrome_acc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_acc.sv
// Sparse-circulant syndrome accumulator: s = seed ^ sum_ch e_ch * h_ch mod (x^R - 1) over GF(2).
// One sparse term per cycle through a shared rotate-and-XOR engine, then popcount of the result.
module syndrome_acc #(
    parameter int R     = 127,
    parameter int W     = 5,
    parameter int POS_W = 8,
    parameter int N     = 2,
    parameter int WT_W  = $clog2(R + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   seed_en,
    input  logic [R-1:0]           s_seed,
    input  logic [N*R-1:0]         e_flat,
    input  logic [N*W*POS_W-1:0]   h_pos_flat,
    output logic                   busy,
    output logic                   done,
    output logic [R-1:0]           s,
    output logic [WT_W-1:0]        s_wt,
    output logic                   err
);

    localparam int NT = N * W;
    localparam int KW = (NT > 1) ? $clog2(NT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FIN
    } state_t;

    state_t             r_state;
    logic [R-1:0]       r_acc;
    logic [KW-1:0]      r_k;
    logic [CW-1:0]      r_ch;
    logic [WW-1:0]      r_w;
    logic               r_err_run;
    logic               r_busy;
    logic               r_done;
    logic [R-1:0]       r_s;
    logic [WT_W-1:0]    r_s_wt;
    logic               r_err;

    logic [R-1:0]       r_e [N];
    logic [POS_W-1:0]   r_h [NT];

    logic [R-1:0]       w_e_in [N];
    logic [POS_W-1:0]   w_h_in [NT];
    logic               w_accept;
    logic [R-1:0]       w_e_sel;
    logic [POS_W-1:0]   w_p;
    logic               w_p_ok;
    logic [R-1:0]       w_rot;
    logic [WT_W-1:0]    w_wt;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_e_unpack
            assign w_e_in[gi] = e_flat[gi*R +: R];
        end
        for (gi = 0; gi < NT; gi++) begin : g_h_unpack
            assign w_h_in[gi] = h_pos_flat[gi*POS_W +: POS_W];
        end
    endgenerate

    assign w_accept = (r_state == S_IDLE) && start;

    // Operand snapshot; contents only matter while ACC is running, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_e <= w_e_in;
            r_h <= w_h_in;
        end
    end

    assign w_e_sel = r_e[r_ch];
    assign w_p     = r_h[r_k];
    assign w_p_ok  = ({1'b0, w_p} < (POS_W + 1)'(R));

    function automatic logic [R-1:0] rotl_c(input logic [R-1:0] x, input int a);
        logic [R-1:0] res;
        for (int i = 0; i < R; i++) begin
            res[i] = x[IW'((i + R - a) % R)];
        end
        return res;
    endfunction

    // Log-depth rotator: stage j rotates by 2^j mod R, so any p < R composes exactly.
    always_comb begin
        w_rot = w_e_sel;
        for (int j = 0; j < POS_W; j++) begin
            if (w_p[j]) begin
                w_rot = rotl_c(w_rot, (2 ** j) % R);
            end
        end
    end

    always_comb begin
        w_wt = '0;
        for (int i = 0; i < R; i++) begin
            w_wt = w_wt + WT_W'(r_acc[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_k       <= '0;
            r_ch      <= '0;
            r_w       <= '0;
            r_err_run <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s       <= '0;
            r_s_wt    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= seed_en ? s_seed : '0;
                        r_k       <= '0;
                        r_ch      <= '0;
                        r_w       <= '0;
                        r_err_run <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_p_ok) begin
                        r_acc <= r_acc ^ w_rot;
                    end else begin
                        r_err_run <= 1'b1;
                    end
                    r_k <= r_k + KW'(1);
                    if (r_w == WW'(W - 1)) begin
                        r_w  <= '0;
                        r_ch <= r_ch + CW'(1);
                    end else begin
                        r_w <= r_w + WW'(1);
                    end
                    if (r_k == KW'(NT - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_s     <= r_acc;
                    r_s_wt  <= w_wt;
                    r_err   <= r_err_run;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign s_wt = r_s_wt;
    assign err  = r_err;

endmodule

// File: tb/tb_syndrome_acc.sv
// Scoreboard bench for syndrome_acc: expectations queued at start acceptance,
// popped and compared (s, s_wt, err, latency) on each done pulse.
module tb_syndrome_acc;

    localparam int R     = 127;
    localparam int W     = 5;
    localparam int POS_W = 8;
    localparam int N     = 2;
    localparam int NT    = N * W;
    localparam int WT_W  = $clog2(R + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 seed_en = 1'b0;
    logic [R-1:0]         s_seed = '0;
    logic [N*R-1:0]       e_flat = '0;
    logic [NT*POS_W-1:0]  h_pos_flat = '0;
    logic                 busy;
    logic                 done;
    logic [R-1:0]         s;
    logic [WT_W-1:0]      s_wt;
    logic                 err;

    syndrome_acc #(.R(R), .W(W), .POS_W(POS_W), .N(N), .WT_W(WT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed_en    (seed_en),
        .s_seed     (s_seed),
        .e_flat     (e_flat),
        .h_pos_flat (h_pos_flat),
        .busy       (busy),
        .done       (done),
        .s          (s),
        .s_wt       (s_wt),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [R-1:0] s;
        int           wt;
        bit           err;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_done = 0;
    int   prev_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [R-1:0] got, input logic [R-1:0] expv);
        n_total++;
        if (got !== expv) $display("FAIL %s: got %h expected %h", tag, got, expv);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [R-1:0] rand_r();
        logic [R-1:0] v;
        for (int i = 0; i < R; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [NT*POS_W-1:0] hpack(input int p[NT]);
        logic [NT*POS_W-1:0] v;
        for (int k = 0; k < NT; k++) v[k*POS_W +: POS_W] = POS_W'(p[k]);
        return v;
    endfunction

    // Reference: scatter every set bit of e_ch forward by p, modulo R.
    function automatic logic [R-1:0] gold(input bit se, input logic [R-1:0] sd,
                                          input logic [N*R-1:0] e, input logic [NT*POS_W-1:0] h,
                                          output bit er);
        logic [R-1:0] r;
        int p;
        r  = se ? sd : '0;
        er = 1'b0;
        for (int k = 0; k < NT; k++) begin
            p = int'(h[k*POS_W +: POS_W]);
            if (p >= R) er = 1'b1;
            else for (int i = 0; i < R; i++)
                if (e[(k / W) * R + i]) r[(i + p) % R] = ~r[(i + p) % R];
        end
        return r;
    endfunction

    function automatic int popc(input logic [R-1:0] v);
        int c = 0;
        for (int i = 0; i < R; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 100) begin
            tick();
            i++;
        end
        if (busy) check_val("idle_timeout", R'(busy), R'(0));
    endtask

    task automatic wait_drain();
        int i = 0;
        while (sb.size() != 0 && i < 100) begin
            tick();
            i++;
        end
        check_val("drain", R'(sb.size()), R'(0));
    endtask

    task automatic issue(input bit se, input logic [R-1:0] sd, input logic [N*R-1:0] e,
                         input logic [NT*POS_W-1:0] h, input logic [R-1:0] xs, input int xwt, input bit xerr);
        exp_t x;
        wait_idle();
        seed_en = se; s_seed = sd; e_flat = e; h_pos_flat = h; start = 1'b1;
        tick();
        x.s = xs; x.wt = xwt; x.err = xerr; x.t0 = cyc;
        sb.push_back(x);
        start = 1'b0;
        // Scramble inputs: the accepted operation must use its latched copy.
        seed_en = 1'($urandom); s_seed = rand_r();
        for (int c = 0; c < N; c++) e_flat[c*R +: R] = rand_r();
        for (int k = 0; k < NT; k++) h_pos_flat[k*POS_W +: POS_W] = POS_W'($urandom);
        check_val("busy_on_accept", R'(busy), R'(1));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                prev_done = last_done;
                last_done = cyc;
                if (sb.size() == 0) check_val("unexpected_done", R'(done), R'(0));
                else begin
                    x = sb.pop_front();
                    check_val("s", s, x.s);
                    check_val("s_wt", R'(s_wt), R'(x.wt));
                    check_val("err", R'(err), R'(x.err));
                    check_val("latency", R'(cyc - x.t0), R'(11));
                    check_val("busy_at_done", R'(busy), R'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [R-1:0]        xs, sd;
    logic [N*R-1:0]      e;
    logic [NT*POS_W-1:0] h;
    int                  pl[NT];
    bit                  xe, se;

    initial begin : driver
        exp_t x;
        repeat (3) tick();
        check_val("rst_s", s, R'(0));
        check_val("rst_s_wt", R'(s_wt), R'(0));
        check_val("rst_err", R'(err), R'(0));
        check_val("rst_busy", R'(busy), R'(0));
        check_val("rst_done", R'(done), R'(0));

        // Unit check, issued in the same cycle reset is released.
        pl = '{0, 1, 2, 3, 4, 10, 20, 30, 40, 50};
        e = '0; e[0] = 1'b1;
        seed_en = 1'b0; s_seed = rand_r(); e_flat = e; h_pos_flat = hpack(pl);
        rst_n = 1'b1; start = 1'b1;
        tick();
        x.s = R'(32'h1F); x.wt = 5; x.err = 1'b0; x.t0 = cyc;
        sb.push_back(x);
        start = 1'b0;
        check_val("busy_after_release", R'(busy), R'(1));

        // Wrap-around with duplicate positions; seed disabled but nonzero.
        pl = '{1, 1, 1, 2, 0, 5, 6, 7, 8, 9};
        e = '0; e[126] = 1'b1;
        xs = '0; xs[0] = 1'b1; xs[1] = 1'b1; xs[126] = 1'b1;
        issue(1'b0, rand_r(), e, hpack(pl), xs, 3, 1'b0);

        // Seed plus two channels, issued back-to-back in the previous done cycle.
        pl = '{5, 0, 0, 0, 0, 7, 0, 0, 0, 0};
        e = '0; e[5] = 1'b1; e[R + 3] = 1'b1;
        sd = '0; sd[10] = 1'b1;
        xs = '0; xs[10] = 1'b1;
        issue(1'b1, sd, e, hpack(pl), xs, 1, 1'b0);
        wait_drain();
        check_val("b2b_gap", R'(last_done - prev_done), R'(12));

        // Out-of-range position skipped and flagged; p=0 pair cancels.
        pl = '{200, 3, 7, 0, 0, 11, 12, 13, 14, 15};
        e = '0; e[0] = 1'b1;
        xs = '0; xs[3] = 1'b1; xs[7] = 1'b1;
        issue(1'b0, '0, e, hpack(pl), xs, 2, 1'b1);

        // Clean operation afterwards must clear err.
        for (int k = 0; k < NT; k++) pl[k] = $urandom_range(0, R - 1);
        for (int c = 0; c < N; c++) e[c*R +: R] = rand_r();
        sd = rand_r(); h = hpack(pl);
        xs = gold(1'b1, sd, e, h, xe);
        issue(1'b1, sd, e, h, xs, popc(xs), xe);

        // Start mid-ACC must be ignored.
        for (int c = 0; c < N; c++) e[c*R +: R] = rand_r();
        h = hpack(pl);
        xs = gold(1'b0, '0, e, h, xe);
        issue(1'b0, '0, e, h, xs, popc(xs), xe);
        repeat (3) tick();
        check_val("busy_mid_acc", R'(busy), R'(1));
        start = 1'b1; seed_en = 1'b1; s_seed = rand_r();
        tick();
        start = 1'b0;
        wait_drain();

        // Reset while ACC term 4 is pending: abandon op, outputs cleared, no done.
        for (int c = 0; c < N; c++) e[c*R +: R] = rand_r();
        xs = gold(1'b0, '0, e, h, xe);
        issue(1'b0, '0, e, h, xs, popc(xs), xe);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check_val("midrst_s", s, R'(0));
        check_val("midrst_s_wt", R'(s_wt), R'(0));
        check_val("midrst_err", R'(err), R'(0));
        check_val("midrst_busy", R'(busy), R'(0));
        check_val("midrst_done", R'(done), R'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();

        // Randomised operations against the reference model.
        for (int n = 0; n < 1000; n++) begin
            se = 1'($urandom);
            sd = rand_r();
            for (int c = 0; c < N; c++) e[c*R +: R] = rand_r();
            for (int k = 0; k < NT; k++)
                pl[k] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(R, 255)) : int'($urandom_range(0, R - 1));
            h = hpack(pl);
            xs = gold(se, sd, e, h, xe);
            issue(se, sd, e, h, xs, popc(xs), xe);
        end
        wait_drain();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
